// File: rtl/controlador_venda.sv
// controlador_venda: vending-machine sale sequencer (credit, inactivity timeout, dispense, change, refund).
// Define MAQ_TROCO_EN to accept overpayment and return change; otherwise only exact payment sells.
module controlador_venda #(
    parameter int unsigned TIMEOUT_CICLOS = 1000,
    parameter int unsigned PRECO0         = 4,
    parameter int unsigned PRECO1         = 5,
    parameter int unsigned PRECO2         = 6,
    parameter int unsigned PRECO3         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       moeda_valida,
    input  logic [1:0] valorMoeda,
    input  logic [1:0] produto_sel,
    input  logic       confirmar,
    input  logic       cancelar,
    output logic [3:0] credito,
    output logic       tempoLimite,
    output logic       moeda_rejeitada,
    output logic       saldo_insuficiente,
    output logic       liberar_produto,
    output logic [1:0] produto_out,
    output logic [3:0] troco,
    output logic       troco_valido,
    output logic       ocupado
);
    localparam int unsigned   TW       = $clog2(TIMEOUT_CICLOS);
    localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [4:0]    CRED_MAX = 5'd8;

    typedef enum logic [2:0] {
        OCIOSO, ACUMULANDO, VERIFICAR, LIBERAR, TROCO, DEVOLVER
    } estado_t;

    function automatic logic [3:0] preco_f(input logic [1:0] s);
        case (s)
            2'd0:    preco_f = 4'(PRECO0);
            2'd1:    preco_f = 4'(PRECO1);
            2'd2:    preco_f = 4'(PRECO2);
            default: preco_f = 4'(PRECO3);
        endcase
    endfunction

    // Prices above the credit ceiling can never be met.
    function automatic logic preco_ok_f(input logic [1:0] s);
        case (s)
            2'd0:    preco_ok_f = (PRECO0 <= 32'd8);
            2'd1:    preco_ok_f = (PRECO1 <= 32'd8);
            2'd2:    preco_ok_f = (PRECO2 <= 32'd8);
            default: preco_ok_f = (PRECO3 <= 32'd8);
        endcase
    endfunction

    estado_t       estado_q, estado_d;
    logic [3:0]    credito_q, credito_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    sel_q, sel_d;
    logic          tempo_q, tempo_d, rej_q, rej_d, saldo_q, saldo_d, lib_q, lib_d;
    logic [1:0]    prod_q, prod_d;
    logic [3:0]    troco_q, troco_d;
    logic          tv_q, tv_d, ocup_q, ocup_d;

    logic [2:0] coin_val;
    logic       coin_present, coin_fits, coin_accept, venda_ok;
    logic [4:0] soma;

    assign coin_val     = (valorMoeda == 2'b11) ? 3'd4 : 3'(valorMoeda);
    assign coin_present = moeda_valida && (valorMoeda != 2'b00);
    assign soma         = 5'(credito_q) + 5'(coin_val);
    assign coin_fits    = (soma <= CRED_MAX);

`ifdef MAQ_TROCO_EN
    assign venda_ok = preco_ok_f(sel_q) && (credito_q >= preco_f(sel_q));
`else
    assign venda_ok = preco_ok_f(sel_q) && (credito_q == preco_f(sel_q));
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            credito_q <= 4'd0;
            timer_q   <= '0;
            sel_q     <= 2'd0;
            tempo_q   <= 1'b0;
            rej_q     <= 1'b0;
            saldo_q   <= 1'b0;
            lib_q     <= 1'b0;
            prod_q    <= 2'd0;
            troco_q   <= 4'd0;
            tv_q      <= 1'b0;
            ocup_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            credito_q <= credito_d;
            timer_q   <= timer_d;
            sel_q     <= sel_d;
            tempo_q   <= tempo_d;
            rej_q     <= rej_d;
            saldo_q   <= saldo_d;
            lib_q     <= lib_d;
            prod_q    <= prod_d;
            troco_q   <= troco_d;
            tv_q      <= tv_d;
            ocup_q    <= ocup_d;
        end
    end

    // Next state: in ACUMULANDO cancel beats timeout beats confirm beats coin
    always_comb begin
        estado_d    = estado_q;
        credito_d   = credito_q;
        timer_d     = timer_q;
        sel_d       = sel_q;
        coin_accept = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (coin_present && coin_fits) begin
                    coin_accept = 1'b1;
                    credito_d   = soma[3:0];
                    timer_d     = '0;
                    estado_d    = ACUMULANDO;
                end
            end
            ACUMULANDO: begin
                if (cancelar || (timer_q == T_MAX)) begin
                    estado_d = DEVOLVER;
                end else if (confirmar) begin
                    sel_d    = produto_sel;
                    timer_d  = timer_q + TW'(1);
                    estado_d = VERIFICAR;
                end else if (coin_present && coin_fits) begin
                    coin_accept = 1'b1;
                    credito_d   = soma[3:0];
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            VERIFICAR: estado_d = venda_ok ? LIBERAR : ACUMULANDO;
            LIBERAR: begin
`ifdef MAQ_TROCO_EN
                estado_d = TROCO;
`else
                estado_d  = OCIOSO;
                credito_d = 4'd0;
                timer_d   = '0;
`endif
            end
            default: begin
                estado_d  = OCIOSO;
                credito_d = 4'd0;
                timer_d   = '0;
            end
        endcase
    end

    // Registered outputs track the state being entered
    always_comb begin
        rej_d   = coin_present && !coin_accept;
        saldo_d = ((estado_q == OCIOSO) && confirmar) ||
                  ((estado_q == VERIFICAR) && !venda_ok);
        lib_d   = (estado_d == LIBERAR);
        prod_d  = (estado_d == LIBERAR) ? sel_q : 2'd0;
        tempo_d = (estado_d == LIBERAR) || (estado_d == DEVOLVER);
        troco_d = 4'd0;
        if (estado_d == TROCO)
            troco_d = credito_q - preco_f(sel_q);
        else if (estado_d == DEVOLVER)
            troco_d = credito_q;
        tv_d    = (estado_d == DEVOLVER) || ((estado_d == TROCO) && (troco_d != 4'd0));
        ocup_d  = (estado_d == VERIFICAR) || (estado_d == LIBERAR) ||
                  (estado_d == TROCO) || (estado_d == DEVOLVER);
    end

    assign credito            = credito_q;
    assign tempoLimite        = tempo_q;
    assign moeda_rejeitada    = rej_q;
    assign saldo_insuficiente = saldo_q;
    assign liberar_produto    = lib_q;
    assign produto_out        = prod_q;
    assign troco              = troco_q;
    assign troco_valido       = tv_q;
    assign ocupado            = ocup_q;

endmodule

// File: tb/tb_controlador_venda.sv
// tb_controlador_venda: directed scoreboard bench for controlador_venda (TIMEOUT_CICLOS=10).
// Each step pushes the expected output vector, clocks once, then pops and compares.
module tb_controlador_venda;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       moeda_valida;
    logic [1:0] valorMoeda;
    logic [1:0] produto_sel;
    logic       confirmar;
    logic       cancelar;
    logic [3:0] credito;
    logic       tempoLimite, moeda_rejeitada, saldo_insuficiente, liberar_produto;
    logic [1:0] produto_out;
    logic [3:0] troco;
    logic       troco_valido, ocupado;

    always #5 clk = ~clk;

    controlador_venda #(.TIMEOUT_CICLOS(10)) dut (
        .clk(clk), .rst_n(rst_n), .moeda_valida(moeda_valida), .valorMoeda(valorMoeda),
        .produto_sel(produto_sel), .confirmar(confirmar), .cancelar(cancelar),
        .credito(credito), .tempoLimite(tempoLimite), .moeda_rejeitada(moeda_rejeitada),
        .saldo_insuficiente(saldo_insuficiente), .liberar_produto(liberar_produto),
        .produto_out(produto_out), .troco(troco), .troco_valido(troco_valido), .ocupado(ocupado)
    );

    logic [15:0] sb_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          passes = 0;

    // Vector layout: credito, tempoLimite, rej, saldo, liberar, produto_out, troco, troco_valido, ocupado
    function automatic logic [15:0] ev(int cr, int tl, int rj, int si, int lb, int po, int tr, int tv, int oc);
        return {4'(cr), 1'(tl), 1'(rj), 1'(si), 1'(lb), 2'(po), 4'(tr), 1'(tv), 1'(oc)};
    endfunction

    function automatic logic [15:0] ev0(int cr);
        return ev(cr, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic check_out();
        logic [15:0] exp_v, obs_v;
        string       t;
        exp_v = sb_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = {credito, tempoLimite, moeda_rejeitada, saldo_insuficiente, liberar_produto,
                 produto_out, troco, troco_valido, ocupado};
        checks++;
        assert (obs_v === exp_v) passes++;
        else $error("FAIL %s observed=%h expected=%h", t, obs_v, exp_v);
    endtask

    task automatic step(input string tag, input logic mv, input logic [1:0] vm, input logic [1:0] ps,
                        input logic cf, input logic cc, input logic [15:0] e);
        moeda_valida = mv;
        valorMoeda   = vm;
        produto_sel  = ps;
        confirmar    = cf;
        cancelar     = cc;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input string tag, input logic [15:0] e);
        step(tag, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, e);
    endtask

    task automatic coin(input string tag, input logic [1:0] vm, input logic [15:0] e);
        step(tag, 1'b1, vm, 2'b00, 1'b0, 1'b0, e);
    endtask

    initial begin
        rst_n = 1'b0;
        idle("reset", ev0(0));
        coin("reset_coin", 2'b11, ev0(0));
        rst_n = 1'b1;
        step("code00_ignored", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, ev0(0));
        step("confirm_idle", 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, ev(0, 0, 0, 1, 0, 0, 0, 0, 0));
        step("cancel_idle", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, ev0(0));

        // Exact purchase of product 1
        coin("exact_c1", 2'b11, ev0(4));
        coin("exact_c2", 2'b01, ev0(5));
        step("exact_conf", 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, ev(5, 0, 0, 0, 0, 0, 0, 0, 1));
        idle("exact_lib", ev(5, 1, 0, 0, 1, 1, 0, 0, 1));
`ifdef MAQ_TROCO_EN
        idle("exact_troco0", ev(5, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
        idle("exact_done", ev0(0));

        // Overpayment: 8 quarters for product 0
        coin("chg_c1", 2'b11, ev0(4));
        coin("chg_c2", 2'b11, ev0(8));
        step("chg_conf", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, ev(8, 0, 0, 0, 0, 0, 0, 0, 1));
`ifdef MAQ_TROCO_EN
        idle("chg_lib", ev(8, 1, 0, 0, 1, 0, 0, 0, 1));
        idle("chg_troco", ev(8, 0, 0, 0, 0, 0, 4, 1, 1));
`else
        idle("chg_refused", ev(8, 0, 0, 1, 0, 0, 0, 0, 0));
        step("chg_cancel", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, ev(8, 1, 0, 0, 0, 0, 8, 1, 1));
`endif
        idle("chg_done", ev0(0));

        // Overflow then cancel
        coin("ovf_c1", 2'b11, ev0(4));
        coin("ovf_c2", 2'b11, ev0(8));
        coin("ovf_rej", 2'b01, ev(8, 0, 1, 0, 0, 0, 0, 0, 0));
        step("ovf_cancel", 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, ev(8, 1, 0, 0, 0, 0, 8, 1, 1));
        idle("ovf_done", ev0(0));

        // Insufficient credit; timer keeps counting from before the confirm
        coin("ins_c1", 2'b10, ev0(2));
        step("ins_conf", 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, ev(2, 0, 0, 0, 0, 0, 0, 0, 1));
        coin("ins_ver_coin", 2'b01, ev(2, 0, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++) idle("ins_wait", ev0(2));
        idle("ins_timeout", ev(2, 1, 0, 0, 0, 0, 2, 1, 1));
        idle("ins_done", ev0(0));

        // Plain timeout after 10 idle cycles
        coin("to_c1", 2'b01, ev0(1));
        for (int i = 0; i < 9; i++) idle("to_wait", ev0(1));
        idle("to_refund", ev(1, 1, 0, 0, 0, 0, 1, 1, 1));
        idle("to_done", ev0(0));

        // A coin at cycle 5 restarts the count
        coin("tr_c1", 2'b01, ev0(1));
        for (int i = 0; i < 4; i++) idle("tr_wait1", ev0(1));
        coin("tr_c2", 2'b01, ev0(2));
        for (int i = 0; i < 9; i++) idle("tr_wait2", ev0(2));
        idle("tr_refund", ev(2, 1, 0, 0, 0, 0, 2, 1, 1));
        idle("tr_done", ev0(0));

        // cancel + confirm + coin together: refund only, coin rejected
        coin("sim_c1", 2'b01, ev0(1));
        step("sim_all", 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, ev(1, 1, 1, 0, 0, 0, 1, 1, 1));
        idle("sim_done", ev0(0));

        // Reset mid-sale discards credit with no refund or change pulse
        coin("rs_c1", 2'b11, ev0(4));
        coin("rs_c2", 2'b11, ev0(8));
`ifdef MAQ_TROCO_EN
        step("rs_conf", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, ev(8, 0, 0, 0, 0, 0, 0, 0, 1));
        idle("rs_lib", ev(8, 1, 0, 0, 1, 0, 0, 0, 1));
`else
        step("rs_conf", 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, ev(8, 0, 0, 0, 0, 0, 0, 0, 1));
`endif
        rst_n = 1'b0;
        idle("rs_reset", ev0(0));
        rst_n = 1'b1;
        idle("rs_idle", ev0(0));
        coin("rs_after", 2'b10, ev0(2));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/controlador_venda.md
Name: controlador_venda

Overview:
- Sale sequencer for the vending machine.
- Tracks inserted credit in quarter units (0.25 steps, max 2.00) and runs a per-sale inactivity timeout.
- Compares credit against a per-product price table and sequences dispense, change and refund.
- Drives `tempoLimite` toward the coin accumulator and owns the end-of-sale decision.

Parameters:
- TIMEOUT_CICLOS, 1000, idle cycles after the last accepted coin before automatic refund (min 2).
- PRECO0, 4, price of product 0 in quarters (4 = 1.00).
- PRECO1, 5, price of product 1 in quarters (1.25).
- PRECO2, 6, price of product 2 in quarters (1.50).
- PRECO3, 8, price of product 3 in quarters (2.00).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- moeda_valida  input  1  one-cycle strobe: a coin is present on valorMoeda.
- valorMoeda  input  2  coin code: 01=0.25, 10=0.50, 11=1.00, 00=none.
- produto_sel  input  2  product selected, sampled on confirmar.
- confirmar  input  1  one-cycle purchase request.
- cancelar  input  1  one-cycle cancel request.
- credito  output  4  current credit in quarters (0..8).
- tempoLimite  output  1  one-cycle pulse when the sale ends (dispense, refund or timeout); clears the accumulator.
- moeda_rejeitada  output  1  one-cycle pulse: coin refused.
- saldo_insuficiente  output  1  one-cycle pulse: confirm refused.
- liberar_produto  output  1  one-cycle dispense pulse.
- produto_out  output  2  product being dispensed; valid with liberar_produto.
- troco  output  4  quarters returned; valid with troco_valido.
- troco_valido  output  1  one-cycle pulse: return troco quarters.
- ocupado  output  1  high in VERIFICAR, LIBERAR, TROCO, DEVOLVER.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=OCIOSO, credito=0, timer=0, produto_out=0, troco=0.
  - All pulse outputs=0, ocupado=0.
  - Reset wins over every other input, including mid-sale; credit is discarded with no refund pulse.
- States: OCIOSO, ACUMULANDO, VERIFICAR, LIBERAR, TROCO, DEVOLVER. Register decode: valor = 1/2/4 quarters for codes 01/10/11.
- Coins are accepted only in OCIOSO or ACUMULANDO, when moeda_valida=1 and valorMoeda≠00.
  - If credito+valor ≤ 8: credito updates at the next edge, timer reloads to 0, OCIOSO moves to ACUMULANDO.
  - If credito+valor > 8, or the coin arrives in any other state: credit unchanged, moeda_rejeitada=1 on the next cycle.
  - moeda_valida with code 00 is ignored silently.
- ACUMULANDO: timer increments every cycle with no accepted coin. At timer==TIMEOUT_CICLOS-1, go to DEVOLVER.
- Same-cycle priority in ACUMULANDO: cancelar > timeout > confirmar > coin.
  - A coin arriving with a winning cancelar, timeout or confirmar is rejected (moeda_rejeitada pulse).
- cancelar goes to DEVOLVER from ACUMULANDO and is ignored in all other states.
- confirmar in ACUMULANDO latches produto_sel and goes to VERIFICAR. confirmar in OCIOSO produces a saldo_insuficiente pulse.
- VERIFICAR (1 cycle):
  - If credito ≥ PRECO[sel]: go to LIBERAR.
  - Otherwise: saldo_insuficiente=1, return to ACUMULANDO with credit and timer unchanged.
- LIBERAR (1 cycle): liberar_produto=1, produto_out=sel, tempoLimite=1; go to TROCO.
- TROCO (1 cycle): troco=credito-PRECO[sel].
  - troco_valido=1 only if troco≠0.
  - credito clears to 0 at the exit edge; go to OCIOSO.
- DEVOLVER (1 cycle): troco=credito, troco_valido=1 (credit is always >0 here), tempoLimite=1. credito clears to 0; go to OCIOSO.
- Total latency confirm→dispense is 2 cycles: confirm at edge N, VERIFICAR at N+1, liberar_produto high during N+2.
- Price arithmetic is 4-bit unsigned. Prices above 8 are illegal and make the product unsellable (always insufficient).

Optional Feature:
- Macro: MAQ_TROCO_EN.
- Defined: behaviour as above; overpayment is accepted and change is returned in TROCO.
- Undefined:
  - VERIFICAR passes only when credito == PRECO[sel] exactly; overpayment gets a saldo_insuficiente pulse and returns to ACUMULANDO.
  - TROCO state is skipped: LIBERAR goes to OCIOSO with credit cleared.
  - troco_valido is asserted only in DEVOLVER.

Test Plan:
- Exact purchase: coins 11 then 01, select 1 (PRECO1=5), confirm → liberar_produto=1, produto_out=1 two cycles after confirm; tempoLimite pulse; no troco_valido; credito=0.
- Change (MAQ_TROCO_EN): coins 11,11 (8), select 0, confirm → dispense, then troco=4, troco_valido=1. Without the macro → saldo_insuficiente pulse, credito stays 8.
- Overflow: coins 11,11 (8) then 01 → moeda_rejeitada pulse, credito stays 8. Then cancelar → troco=8, troco_valido, tempoLimite.
- Insufficient: coin 10 (2), select 3, confirm → saldo_insuficiente pulse, state back to ACUMULANDO, credito=2, timer not reset.
- Timeout (TIMEOUT_CICLOS=10): coin 01, then idle 10 cycles → DEVOLVER with troco=1, troco_valido and tempoLimite pulses. A coin at cycle 5 restarts the count.
- Simultaneous/reset: cancelar+confirmar+coin same cycle → refund only, coin rejected. rst_n=0 during TROCO → all outputs 0 next edge, no troco pulse.
